// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port, synchronous-read data memory between the CPU
//   MEM stage and a host port that moves 128-bit blocks as four 32-bit beats.
//   The CPU normally has priority. A waiting host takes over once it has
//   waited STARVE_MAX cycles. While a host burst is on the memory port, a
//   CPU request is frozen through cpu_stall.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   cpu_*            pipeline request (req/we/addr/wdata), read data, stall
//   host_valid/ready block request handshake; host_we selects write/read
//   host_addr        128-bit block address (word address without 2 LSBs)
//   host_wdata       write block, word k at bits [32k+31:32k]
//   host_rvalid      one-cycle pulse when host_rdata holds a new read block
//   host_rdata       assembled read block, held until the next read completes
//   mem_*            memory port (en/we/addr/wdata, rdata valid 1 cycle later)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_stall,
    input  logic                host_valid,
    output logic                host_ready,
    input  logic                host_we,
    input  logic [ADDR_W-3:0]   host_addr,
    input  logic [127:0]        host_wdata,
    output logic                host_rvalid,
    output logic [127:0]        host_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t             state_q;
    logic [1:0]         beat_q;
    logic [7:0]         wait_q;
    logic               we_q;
    logic [ADDR_W-3:0]  blk_q;
    logic [3:0][31:0]   wdata_q;
    logic [2:0][31:0]   rbuf_q;
    logic [127:0]       rdata_q;
    logic               rvalid_q;
    logic               handshake;

    // Gate with rst so the host is never accepted while reset is held.
    assign host_ready = rst && (state_q == IDLE) && (!cpu_req || (wait_q == STARVE_LIM));
    assign handshake  = host_valid && host_ready;

    assign cpu_stall   = cpu_req && (state_q == BURST);
    assign cpu_rdata   = mem_rdata;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;

    // The host owns the memory port only during BURST. In IDLE and RDWAIT
    // the CPU request passes straight through.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        mem_en    = cpu_req;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (state_q == BURST) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = {blk_q, beat_q};   // beat only in the 2 LSBs: no block wrap
            mem_wdata = wdata_q[beat_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: even the data buffers are reset; an aborted read must not
            // leave a stale partial block that could look like a valid result.
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            wait_q   <= 8'd0;
            we_q     <= 1'b0;
            blk_q    <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            // NOTE: all state here uses <= so every register samples the
            // values from before this edge, whatever the statement order.
            rvalid_q <= 1'b0;

            // Starvation counter: counts refused host cycles, saturating.
            if (handshake || !host_valid) begin
                wait_q <= 8'd0;
            end else if (wait_q != STARVE_LIM) begin
                wait_q <= wait_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        we_q    <= host_we;
                        blk_q   <= host_addr;
                        wdata_q <= host_wdata;
                        beat_q  <= 2'd0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    beat_q <= beat_q + 2'd1;
                    // mem_rdata is one beat behind the address, so beat k
                    // stores the word read by beat k-1.
                    if (!we_q) begin
                        case (beat_q)
                            2'd1:    rbuf_q[0] <= mem_rdata;
                            2'd2:    rbuf_q[1] <= mem_rdata;
                            2'd3:    rbuf_q[2] <= mem_rdata;
                            default: ;
                        endcase
                    end
                    if (beat_q == 2'd3) begin
                        state_q <= we_q ? IDLE : RDWAIT;
                    end
                end
                RDWAIT: begin
                    // Word 3 arrives now. The whole block is published at once,
                    // so host_rdata stays stable until a read finishes.
                    rdata_q  <= {mem_rdata, rbuf_q[2], rbuf_q[1], rbuf_q[0]};
                    rvalid_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, data-memory word-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 8, host wait cycles before the host overrides CPU priority (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  pipeline MEM-stage access request.
REQ-006 cpu_we  input  1  CPU write enable.
REQ-007 cpu_addr  input  ADDR_W  CPU word address.
REQ-008 cpu_wdata  input  32  CPU write data.
REQ-009 cpu_rdata  output  32  CPU read data, equal to mem_rdata.
REQ-010 cpu_stall  output  1  freeze request to the pipeline/hazard unit.
REQ-011 host_valid  input  1  host block-transfer request.
REQ-012 host_ready  output  1  host request accepted when high with host_valid.
REQ-013 host_we  input  1  host write (1) or read (0).
REQ-014 host_addr  input  ADDR_W-2  128-bit block address.
REQ-015 host_wdata  input  128  host write block.
REQ-016 host_rvalid  output  1  one-cycle pulse: host_rdata valid.
REQ-017 host_rdata  output  128  assembled read block.
REQ-018 mem_en, mem_we  output  1 each  memory enable and write enable.
REQ-019 mem_addr  output  ADDR_W  memory word address.
REQ-020 mem_wdata  output  32  memory write data.
REQ-021 mem_rdata  input  32  synchronous memory read data, valid one cycle after a read enable.

Function
REQ-022 SHALL implement FSM states IDLE, BURST, RDWAIT, plus a 2-bit beat counter.
REQ-023 IDLE: mem_en=cpu_req, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata (combinational pass-through).
REQ-024 host_ready SHALL be 1 only in IDLE, when (!cpu_req or wait_cnt==STARVE_MAX).
REQ-025 Handshake (host_valid && host_ready at an edge) SHALL latch host_we, host_addr, host_wdata, clear beat, and enter BURST; the CPU is still served in the handshake cycle.
REQ-026 BURST beat k (0..3): mem_en=1, mem_we=latched we, mem_addr={blk,k}, mem_wdata=wdata[32k+31:32k]; beat increments each cycle.
REQ-027 After beat 3: write goes to IDLE; read goes to RDWAIT.
REQ-028 Read word k SHALL be captured from mem_rdata into host_rdata[32k+31:32k] on the cycle after beat k is issued; word 3 is captured in RDWAIT.
REQ-029 RDWAIT SHALL go to IDLE and raise host_rvalid for exactly one cycle in the following cycle; host_rdata holds until the next read completes.
REQ-030 In RDWAIT the memory port SHALL be given to the CPU as in IDLE, but host_ready SHALL stay 0.
REQ-031 cpu_stall SHALL equal cpu_req && (state==BURST); it SHALL be 0 otherwise.
REQ-032 wait_cnt SHALL increment, saturating at STARVE_MAX, each cycle host_valid && !host_ready; it SHALL clear on handshake or when host_valid=0.
REQ-033 Latency: write occupies 4 BURST cycles after the handshake; read has host_rvalid 6 cycles after the handshake edge.
REQ-034 Address arithmetic SHALL not wrap across blocks; the beat index occupies only the 2 LSBs.

Reset
REQ-035 On rst=0 asynchronously: state=IDLE, beat=0, wait_cnt=0, host_rvalid=0, host_rdata=0, latched registers=0.
REQ-036 Reset mid-BURST SHALL abort the transfer with no further host-driven mem_en, no host_rvalid pulse and no partial-read completion.
REQ-037 While rst=0, host_ready=0 and cpu_stall=0; mem_* follow the CPU pass-through.

Verification
REQ-038 Host write, blk=5, wdata=0x44..33..22..11 words, cpu_req=0 -> mem writes at 20,21,22,23 of words 0x11..,0x22..,0x33..,0x44.. on 4 consecutive cycles, then IDLE.
REQ-039 Host read, blk=2, memory words 8..11 = A,B,C,D -> host_rvalid single pulse 6 cycles after handshake, host_rdata={D,C,B,A}.
REQ-040 cpu_req held 1 continuously with host_valid=1 -> host_ready rises after exactly 8 waiting cycles; cpu_stall=1 for the following 4 cycles, then 0.
REQ-041 cpu_req during RDWAIT with cpu_addr=3 -> mem_addr=3 that cycle, cpu_stall=0, and the host word 3 is still captured correctly.
REQ-042 rst asserted at BURST beat 1 -> mem_en follows cpu_req immediately, host_rvalid never pulses, state IDLE after release.
REQ-043 Back-to-back host reads with host_valid held -> second handshake in the cycle host_rvalid pulses; both blocks return correctly.
